// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit registered ALU.
// A purely combinational stage computes one of 16 operations and its status
// flags from the current operands. The result and the four flags are then
// captured on every rising clock edge, so the outputs show the previous
// cycle's operation. Apart from the output registers, the block holds no state.

module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       negative,
    output logic       overflow
);

    // Opcode map
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_ROL  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_ASR  = 4'd15;

    // Shared arithmetic results. The 9-bit forms expose the carry or borrow in bit 8.
    logic [8:0] sum_ext;
    logic [8:0] diff_ext;
    logic [7:0] inc_val;
    logic [7:0] dec_val;

    assign sum_ext  = {1'b0, a_in} + {1'b0, b_in};
    assign diff_ext = {1'b0, a_in} - {1'b0, b_in};
    assign inc_val  = a_in + 8'd1;
    assign dec_val  = a_in - 8'd1;

    // Next-state values for the output registers
    logic [7:0] result_d;
    logic       carry_d;
    logic       overflow_d;
    logic       zero_d;
    logic       negative_d;

    // Output registers
    logic [7:0] result_q;
    logic       carry_q;
    logic       zero_q;
    logic       negative_q;
    logic       overflow_q;

    // Select the operation result and its carry and overflow for the current opcode
    always_comb begin
        result_d   = 8'h00;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                result_d   = sum_ext[7:0];
                carry_d    = sum_ext[8];
                // Operands share a sign, and the sum leaves that sign.
                overflow_d = (a_in[7] == b_in[7]) && (sum_ext[7] != a_in[7]);
            end
            OP_SUB: begin
                result_d   = diff_ext[7:0];
                // Bit 8 of the extended difference is the borrow (A < B unsigned).
                carry_d    = diff_ext[8];
                overflow_d = (a_in[7] != b_in[7]) && (diff_ext[7] != a_in[7]);
            end
            OP_INC: begin
                result_d   = inc_val;
                carry_d    = (a_in == 8'hFF);
                overflow_d = (a_in == 8'h7F);
            end
            OP_DEC: begin
                result_d   = dec_val;
                carry_d    = (a_in == 8'h00);
                overflow_d = (a_in == 8'h80);
            end
            OP_AND:  result_d = a_in & b_in;
            OP_OR:   result_d = a_in | b_in;
            OP_XOR:  result_d = a_in ^ b_in;
            OP_NOT:  result_d = ~a_in;
            OP_NAND: result_d = ~(a_in & b_in);
            OP_NOR:  result_d = ~(a_in | b_in);
            OP_XNOR: result_d = ~(a_in ^ b_in);
            OP_SHL: begin
                result_d = {a_in[6:0], 1'b0};
                carry_d  = a_in[7];
            end
            OP_SHR: begin
                result_d = {1'b0, a_in[7:1]};
                carry_d  = a_in[0];
            end
            OP_ROL: begin
                result_d = {a_in[6:0], a_in[7]};
                carry_d  = a_in[7];
            end
            OP_ROR: begin
                result_d = {a_in[0], a_in[7:1]};
                carry_d  = a_in[0];
            end
            OP_ASR: begin
                result_d = {a_in[7], a_in[7:1]};
                carry_d  = a_in[0];
            end
            default: begin
                result_d   = 8'h00;
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
    end

    // Derive the zero and negative flags from the newly computed result
    always_comb begin
        zero_d     = (result_d == 8'h00);
        negative_d = result_d[7];
    end

    // Capture result and flags every cycle; asynchronous reset clears everything, including zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= 8'h00;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: self-checking bench for alu_8bit.
// The bench applies directed vectors from the test plan, runs an opcode sweep,
// exercises the asynchronous reset, and then applies randomized operations.
// Each observed output is packed as {result, carry, zero, negative, overflow}.

module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] op;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks_total;
    int checks_failed;

    alu_8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_in     (a_in),
        .b_in     (b_in),
        .op       (op),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: computes the result with integer arithmetic and signed range checks
    function automatic logic [11:0] ref_model(input logic [3:0] f, input logic [7:0] a8, input logic [7:0] b8);
        int a, b, sa, sb, s, r, c, v;
        logic [7:0] r8;
        a  = int'(a8);
        b  = int'(b8);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = 0;
        c  = 0;
        v  = 0;
        case (f)
            4'd0: begin
                s = a + b; r = s % 256; c = (s >= 256) ? 1 : 0;
                v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            4'd1: begin
                r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
                v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            4'd2: begin
                r = (a + 1) % 256; c = (a == 255) ? 1 : 0;
                v = ((sa + 1) > 127) ? 1 : 0;
            end
            4'd3: begin
                r = (a + 255) % 256; c = (a == 0) ? 1 : 0;
                v = ((sa - 1) < -128) ? 1 : 0;
            end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = 255 - a;
            4'd8:  r = 255 - (a & b);
            4'd9:  r = 255 - (a | b);
            4'd10: r = 255 - (a ^ b);
            4'd11: begin r = (a * 2) % 256;             c = a / 128; end
            4'd12: begin r = a / 2;                     c = a % 2;   end
            4'd13: begin r = (a * 2) % 256 + a / 128;   c = a / 128; end
            4'd14: begin r = a / 2 + (a % 2) * 128;     c = a % 2;   end
            default: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
        endcase
        r8 = r[7:0];
        return {r8, (c != 0), (r8 == 8'h00), (r >= 128), (v != 0)};
    endfunction

    // Count a comparison and report a mismatch
    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks_total++;
        if (obs !== exp) begin
            checks_failed++;
            $display("FAIL %s: got %h (r=%h cznv=%b) expected %h (r=%h cznv=%b)",
                     tag, obs, obs[11:4], obs[3:0], exp, exp[11:4], exp[3:0]);
        end
    endtask

    function automatic logic [11:0] observed();
        return {result, carry, zero, negative, overflow};
    endfunction

    // Drive one operation, let it be captured, and sample just after the edge
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        a_in = a;
        b_in = b;
        op   = f;
        @(posedge clk);
        #1;
        $display("txn op=%0d a=%h b=%h -> result=%h c=%b z=%b n=%b v=%b",
                 f, a, b, result, carry, zero, negative, overflow);
    endtask

    // Directed vectors from the test plan, with expected values written out
    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [11:0] exp;
    } vec_t;

    vec_t dir_vecs[$];
    logic [7:0] sweep_exp[16];

    initial begin
        checks_total  = 0;
        checks_failed = 0;

        dir_vecs.push_back('{"add_carry_zero", 8'hFF, 8'h01, 4'd0,  {8'h00, 4'b1100}});
        dir_vecs.push_back('{"add_ovf",        8'h7F, 8'h01, 4'd0,  {8'h80, 4'b0011}});
        dir_vecs.push_back('{"sub_ovf",        8'h80, 8'h01, 4'd1,  {8'h7F, 4'b0001}});
        dir_vecs.push_back('{"sub_borrow",     8'h00, 8'h01, 4'd1,  {8'hFF, 4'b1010}});
        dir_vecs.push_back('{"sub_equal",      8'h5A, 8'h5A, 4'd1,  {8'h00, 4'b0100}});
        dir_vecs.push_back('{"shl_81",         8'h81, 8'h00, 4'd11, {8'h02, 4'b1000}});
        dir_vecs.push_back('{"shr_81",         8'h81, 8'h00, 4'd12, {8'h40, 4'b1000}});
        dir_vecs.push_back('{"rol_81",         8'h81, 8'h00, 4'd13, {8'h03, 4'b1000}});
        dir_vecs.push_back('{"ror_81",         8'h81, 8'h00, 4'd14, {8'hC0, 4'b1010}});
        dir_vecs.push_back('{"asr_81",         8'h81, 8'h00, 4'd15, {8'hC0, 4'b1010}});
        dir_vecs.push_back('{"asr_80",         8'h80, 8'h00, 4'd15, {8'hC0, 4'b0010}});
        dir_vecs.push_back('{"inc_ff",         8'hFF, 8'h55, 4'd2,  {8'h00, 4'b1100}});
        dir_vecs.push_back('{"inc_7f",         8'h7F, 8'h55, 4'd2,  {8'h80, 4'b0011}});
        dir_vecs.push_back('{"dec_00",         8'h00, 8'h55, 4'd3,  {8'hFF, 4'b1010}});
        dir_vecs.push_back('{"dec_80",         8'h80, 8'h55, 4'd3,  {8'h7F, 4'b0001}});

        sweep_exp = '{8'hE1, 8'h69, 8'hA6, 8'hA4, 8'h24, 8'hBD, 8'h99, 8'h5A,
                      8'hDB, 8'h42, 8'h66, 8'h4A, 8'h52, 8'h4B, 8'hD2, 8'hD2};

        a_in  = 8'h00;
        b_in  = 8'h00;
        op    = 4'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_val("reset_initial", observed(), 12'h000);

        // Hold reset across edges with inputs that would give a non-zero result
        a_in = 8'h7F; b_in = 8'h01; op = 4'd0;
        @(posedge clk); #1 check_val("reset_hold", observed(), 12'h000);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors
        foreach (dir_vecs[i]) begin
            run_op(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].f);
            check_val(dir_vecs[i].tag, observed(), dir_vecs[i].exp);
        end

        // Opcode sweep with one operation per cycle
        for (int k = 0; k < 16; k++) begin
            run_op(8'hA5, 8'h3C, 4'(k));
            check_val($sformatf("sweep_res_op%0d", k), {result, 4'h0}, {sweep_exp[k], 4'h0});
            check_val($sformatf("sweep_full_op%0d", k), observed(), ref_model(4'(k), 8'hA5, 8'h3C));
        end

        // Assert async reset mid-cycle, hold it, then release
        run_op(8'h7F, 8'h01, 4'd0);
        check_val("pre_reset_value", observed(), {8'h80, 4'b0011});
        #3 rst_n = 1'b0;
        #1 check_val("async_reset_midcycle", observed(), 12'h000);
        @(posedge clk); #1 check_val("reset_edge1", observed(), 12'h000);
        @(posedge clk); #1 check_val("reset_edge2", observed(), 12'h000);
        a_in = 8'h12; b_in = 8'h34; op = 4'd0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1 check_val("release_first_edge", observed(), {8'h46, 4'b0000});

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ra, rb;
            logic [3:0] rf;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rf = 4'($urandom_range(15, 0));
            if (n % 10 == 0) ra = (n % 20 == 0) ? 8'hFF : 8'h80;
            run_op(ra, rb, rf);
            check_val($sformatf("rand%0d_op%0d", n, rf), observed(), ref_model(rf, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", checks_failed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

8-bit registered arithmetic/logic unit. It takes two 8-bit operands and a 4-bit opcode, computes one of 16 operations, and registers the result and four status flags on the rising clock edge. The block is the datapath core behind the ALU interface bundle (operand, opcode and result signals). It is driven by sequencers that may change the opcode every cycle and the operands at any time.

## Interface
Parameters:
- none (width fixed at 8 bits, opcode fixed at 4 bits)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_in  input  8  operand A
- b_in  input  8  operand B
- op  input  4  operation select; all 16 codes are defined
- result  output  8  registered operation result
- carry  output  1  registered carry / borrow / shifted-out bit
- zero  output  1  registered, high when result == 0x00
- negative  output  1  registered, equals result[7]
- overflow  output  1  registered signed (two's-complement) overflow

## Operation
Opcode map (R = 8-bit result; C = carry; V = overflow):
- 0 ADD: R = A+B. C = bit 8 of the 9-bit sum. V = A and B have the same sign and R's sign differs.
- 1 SUB: R = A−B. C = borrow, i.e. 1 when A < B unsigned. V = A and B have different signs and R's sign differs from A.
- 2 INC: R = A+1. C = 1 when A = 0xFF. V = 1 when A = 0x7F.
- 3 DEC: R = A−1. C = 1 when A = 0x00. V = 1 when A = 0x80.
- 4 AND, 5 OR, 6 XOR: bitwise. C = 0, V = 0.
- 7 NOT: R = ~A. C = 0, V = 0.
- 8 NAND, 9 NOR, 10 XNOR: bitwise. C = 0, V = 0.
- 11 SHL: R = {A[6:0],0}. C = A[7]. V = 0.
- 12 SHR (logical): R = {0,A[7:1]}. C = A[0]. V = 0.
- 13 ROL: R = {A[6:0],A[7]}. C = A[7]. V = 0.
- 14 ROR: R = {A[0],A[7:1]}. C = A[0]. V = 0.
- 15 ASR: R = {A[7],A[7:1]}. C = A[0]. V = 0.

Flag and width rules:
- zero and negative are derived from the newly computed R for every opcode.
- All arithmetic wraps modulo 256 (e.g. 0xFF+0x01 → 0x00).
- Unary and shift opcodes (2, 3, 7, 11–15) ignore B.
- No state other than the output registers. No handshake; a new operation is accepted every cycle.

## Timing
- Combinational compute from a_in, b_in and op. All five outputs are captured on each clk rising edge.
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. Opcode and operands may all change every cycle with no restriction.
- Reset: when rst_n goes low, result = 0x00 and carry, zero, negative, overflow = 0 immediately, independent of clk.
- The reset value of zero is 0, not derived from the reset value of result.
- While rst_n is low, outputs hold the reset values.
- Release: the first capture occurs on the first clk rising edge after rst_n goes high.
- Reset asserted mid-stream discards the in-flight operation. There is no partial update.
- Inputs must meet setup/hold relative to clk. The block has no input synchronizers.

## Test plan
- ADD carry/zero: A=0xFF, B=0x01, op=0 → next cycle result=0x00, C=1, Z=1, N=0, V=0.
- ADD signed overflow: A=0x7F, B=0x01, op=0 → result=0x80, C=0, Z=0, N=1, V=1. SUB: A=0x80, B=0x01, op=1 → 0x7F, V=1, C=0.
- SUB borrow: A=0x00, B=0x01, op=1 → result=0xFF, C=1, N=1, V=0. SUB equal: A=0x5A, B=0x5A → 0x00, Z=1, C=0.
- Shifts/rotates with A=0x81:
  - SHL → 0x02, C=1.
  - SHR → 0x40, C=1.
  - ROL → 0x03, C=1.
  - ROR → 0xC0, C=1.
  - ASR → 0xC0, C=1.
  - ASR with A=0x80 → 0xC0, C=0, N=1.
- Opcode sweep: hold A=0xA5, B=0x3C and step op 0→15 one per cycle. Each cycle's outputs must match the model for the previous cycle's op. Expected sequence:
  - ADD 0xE1, SUB 0x69, INC 0xA6, DEC 0xA4
  - AND 0x24, OR 0xBD, XOR 0x99, NOT 0x5A
  - NAND 0xDB, NOR 0x42, XNOR 0x66
  - SHL 0x4A, SHR 0x52, ROL 0x4B, ROR 0xD2, ASR 0xD2
- Async reset: drive a non-zero result, then assert rst_n low between clock edges → outputs 0 before the next edge. Hold reset across edges → outputs stay 0. Release reset → the first edge loads the current computation.
